// File: rtl/apb_slave_regs_pkg.sv
// Shared widths, register offsets and FSM states for apb_slave_regs.
// Imported by the top level and by the register bank.
package apb_slave_regs_pkg;

  localparam int PADDR_WIDTH    = 32;
  localparam int APB_DATA_WIDTH = 32;
  localparam int IDX_W          = 4;
  localparam int WAIT_W         = 4;

  localparam logic [5:0] CTRL_OFS     = 6'h00;
  localparam logic [5:0] ID_OFS       = 6'h04;
  localparam logic [5:0] STATUS_OFS   = 6'h08;
  localparam logic [5:0] SCRATCH0_OFS = 6'h0C;

  localparam logic [IDX_W-1:0] CTRL_IDX   = CTRL_OFS[5:2];
  localparam logic [IDX_W-1:0] ID_IDX     = ID_OFS[5:2];
  localparam logic [IDX_W-1:0] STATUS_IDX = STATUS_OFS[5:2];
  localparam int               SCR_LO     = int'(SCRATCH0_OFS[5:2]);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/apb_regbank.sv
// Register bank: CTRL, ID, STATUS counters, scratch words, decode and read mux.
// Ports: addr/wr decode live bus; done/done_* commit a finished transfer.
module apb_regbank
  import apb_slave_regs_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA9B2_0001
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic [PADDR_WIDTH-1:0]    addr,
  input  logic                      wr,
  output logic [APB_DATA_WIDTH-1:0] rdata,
  output logic                      err,
  output logic [WAIT_W-1:0]         wait_cfg,
  input  logic                      done,
  input  logic                      done_err,
  input  logic                      done_wr,
  input  logic [IDX_W-1:0]          done_idx,
  input  logic [APB_DATA_WIDTH-1:0] wdata
);

  localparam logic [IDX_W:0] NREG = (IDX_W+1)'(NUM_REGS);

  logic [WAIT_W-1:0]         wait_q;
  logic [15:0]               ok_cnt;
  logic [15:0]               err_cnt;
  logic [APB_DATA_WIDTH-1:0] mem [SCR_LO:NUM_REGS-1];
  logic [IDX_W-1:0]          idx;
  logic                      ro_hit;

  assign wait_cfg = wait_q;
  assign idx      = addr[IDX_W+1:2];
  assign ro_hit   = wr && (idx == ID_IDX || idx == STATUS_IDX);

  always_comb begin
    err = (addr[1:0] != 2'b00)
       || (|addr[PADDR_WIDTH-1:IDX_W+2])
       || ({1'b0, idx} >= NREG)
       || ro_hit;
  end

  always_comb begin
    rdata = '0;
    if (!err) begin
      case (idx)
        CTRL_IDX:   rdata = {{(APB_DATA_WIDTH-WAIT_W){1'b0}}, wait_q};
        ID_IDX:     rdata = ID_VALUE;
        STATUS_IDX: rdata = {err_cnt, ok_cnt};
        default: begin
          for (int i = SCR_LO; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) rdata = mem[i];
        end
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      wait_q  <= '0;
      ok_cnt  <= '0;
      err_cnt <= '0;
      for (int i = SCR_LO; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (done) begin
      if (done_err) begin
        if (err_cnt != 16'hFFFF)
          err_cnt <= err_cnt + 16'd1;
      end else begin
        ok_cnt <= ok_cnt + 16'd1;
      end
      if (done_wr) begin
        if (done_idx == CTRL_IDX)
          wait_q <= wdata[WAIT_W-1:0];
        for (int i = SCR_LO; i < NUM_REGS; i++)
          if (done_idx == IDX_W'(i)) mem[i] <= wdata;
      end
    end
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB responder top: setup/wait/ready FSM with wait counter, registered outputs.
// Ports: APB psel/penable/paddr/pwrite/pwdata in; pready_x/pslverr_x/prdata_x out.
module apb_slave_regs
  import apb_slave_regs_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA9B2_0001
) (
  input  logic                      hclk,
  input  logic                      hreset_n,
  input  logic                      psel,
  input  logic                      penable,
  input  logic [PADDR_WIDTH-1:0]    paddr,
  input  logic                      pwrite,
  input  logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [APB_DATA_WIDTH-1:0] prdata_x,
  output logic                      pready_x,
  output logic                      pslverr_x
);

  state_t                    state;
  logic [WAIT_W-1:0]         wcnt;
  logic                      wr_q;
  logic                      err_q;
  logic [IDX_W-1:0]          idx_q;
  logic [APB_DATA_WIDTH-1:0] rd_q;

  logic [APB_DATA_WIDTH-1:0] bank_rdata;
  logic                      bank_err;
  logic [WAIT_W-1:0]         wait_cfg;
  logic                      done;
  logic                      setup;

  // A transfer completes only if psel is still held in the READY cycle.
  assign done  = (state == ST_READY) && psel;
  assign setup = psel && !penable;

  apb_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .addr     (paddr),
    .wr       (pwrite),
    .rdata    (bank_rdata),
    .err      (bank_err),
    .wait_cfg (wait_cfg),
    .done     (done),
    .done_err (err_q),
    .done_wr  (wr_q && !err_q),
    .done_idx (idx_q),
    .wdata    (pwdata)
  );

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state     <= ST_IDLE;
      wcnt      <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      idx_q     <= '0;
      rd_q      <= '0;
      pready_x  <= 1'b0;
      pslverr_x <= 1'b0;
      prdata_x  <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (setup) begin
            wr_q  <= pwrite;
            err_q <= bank_err;
            idx_q <= paddr[IDX_W+1:2];
            rd_q  <= pwrite ? '0 : bank_rdata;
            if (wait_cfg == '0) begin
              state     <= ST_READY;
              pready_x  <= 1'b1;
              pslverr_x <= bank_err;
              prdata_x  <= pwrite ? '0 : bank_rdata;
            end else begin
              state <= ST_WAIT;
              wcnt  <= wait_cfg;
            end
          end
        end
        ST_WAIT: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (penable) begin
            if (wcnt == WAIT_W'(1)) begin
              state     <= ST_READY;
              pready_x  <= 1'b1;
              pslverr_x <= err_q;
              prdata_x  <= rd_q;
            end
            wcnt <= wcnt - WAIT_W'(1);
          end
        end
        ST_READY: begin
          state     <= ST_IDLE;
          pready_x  <= 1'b0;
          pslverr_x <= 1'b0;
          prdata_x  <= '0;
        end
        default: begin
          state     <= ST_IDLE;
          pready_x  <= 1'b0;
          pslverr_x <= 1'b0;
          prdata_x  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
// Scoreboard bench for apb_slave_regs: random and directed APB traffic
// checked against a behavioural register-map model.
module tb_apb_slave_regs;
  import apb_slave_regs_pkg::*;

  localparam int          NREGS = 8;
  localparam logic [31:0] IDV   = 32'hA9B2_0001;

  logic        hclk = 1'b0;
  logic        hreset_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic [31:0] paddr = '0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata_x;
  logic        pready_x;
  logic        pslverr_x;

  apb_slave_regs #(.NUM_REGS(NREGS), .ID_VALUE(IDV)) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata_x  (prdata_x),
    .pready_x  (pready_x),
    .pslverr_x (pslverr_x)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model of the register map
  logic [31:0] m_scr [NREGS];
  int          m_wait;
  int          m_ok;
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) m_scr[i] = '0;
    m_wait = 0;
    m_ok   = 0;
    m_err  = 0;
  endfunction

  function automatic exp_t predict(input logic [31:0] a, input logic w,
                                   input logic [31:0] d);
    exp_t e;
    int   widx;
    logic bad;
    widx = int'(a[31:2]);
    bad  = (a % 4 != 0) || (widx >= NREGS) || (w && (widx == 1 || widx == 2));
    e.lat = m_wait + 1;
    e.err = bad;
    e.rdata = '0;
    if (!bad && !w) begin
      if (widx == 0)      e.rdata = 32'(m_wait);
      else if (widx == 1) e.rdata = IDV;
      else if (widx == 2) e.rdata = {16'(m_err), 16'(m_ok)};
      else                e.rdata = m_scr[widx];
    end
    if (bad) begin
      if (m_err < 65535) m_err++;
    end else begin
      m_ok = (m_ok + 1) % 65536;
      if (w && widx == 0)  m_wait = int'(d % 16);
      else if (w)          m_scr[widx] = d;
    end
    return e;
  endfunction

  // Monitor: pops one expectation per completed transfer.
  int acc = 0;
  always @(negedge hclk) begin
    exp_t e;
    if (!hreset_n) begin
      acc = 0;
    end else begin
      if (psel && penable) acc++;
      if (pready_x) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pready at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("prdata", prdata_x, e.rdata);
          chk("pslverr", 32'(pslverr_x), 32'(e.err));
          chk("latency", 32'(acc), 32'(e.lat));
        end
        acc = 0;
      end else begin
        chk("idle_outputs", prdata_x | 32'(pslverr_x), 32'h0);
      end
      if (!psel) acc = 0;
    end
  end

  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d);
    int n;
    sb.push_back(predict(a, w, d));
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge hclk); #1;
    penable = 1'b1;
    n = 0;
    forever begin
      @(negedge hclk);
      if (pready_x) break;
      n++;
      if (n > 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout addr %h", a);
        void'(sb.pop_back());
        break;
      end
    end
    @(posedge hclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic abort_xfer(input logic [31:0] a, input logic w,
                            input logic [31:0] d, input int k);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    @(posedge hclk); #1;
    penable = 1'b1;
    repeat (k) @(posedge hclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    int          k;
    int          idx;
    model_reset();
    repeat (3) @(posedge hclk);
    #1 hreset_n = 1'b1;

    // reset state and basic zero-wait traffic
    apb(32'h08, 1'b0, 0);
    apb(32'h00, 1'b0, 0);
    apb(32'h00, 1'b1, 32'h0);
    apb(32'h0C, 1'b1, 32'hDEADBEEF);
    apb(32'h0C, 1'b0, 0);
    apb(32'h08, 1'b0, 0);
    // wait states take effect on the following transfer
    apb(32'h00, 1'b1, 32'hFFFF_FFF3);
    apb(32'h04, 1'b0, 0);
    apb(32'h00, 1'b0, 0);
    apb(32'h00, 1'b1, 32'h0);
    // error paths
    apb(32'h08, 1'b1, 32'h12345678);
    apb(32'h20, 1'b0, 0);
    apb(32'h0E, 1'b0, 0);
    apb(32'h04, 1'b1, 32'h1);
    apb(32'h0000_0100, 1'b0, 0);
    apb(32'h08, 1'b0, 0);
    // penable with no setup phase is ignored
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b1; paddr = 32'h0C; pwrite = 1'b0;
    repeat (3) @(posedge hclk);
    #1 psel = 1'b0; penable = 1'b0;
    apb(32'h08, 1'b0, 0);
    // abort during wait
    apb(32'h00, 1'b1, 32'h5);
    abort_xfer(32'h10, 1'b1, 32'h5555_AAAA, 1);
    apb(32'h10, 1'b0, 0);
    apb(32'h08, 1'b0, 0);
    apb(32'h00, 1'b1, 32'h0);

    // random traffic
    for (int i = 0; i < 200; i++) begin
      k   = int'($urandom_range(0, 19));
      idx = int'($urandom_range(0, 15));
      w   = 1'($urandom_range(0, 1));
      d   = $urandom;
      a   = 32'(idx * 4);
      if (k == 0)      a = a | 32'($urandom_range(1, 3));
      else if (k == 1) a = a | (32'h1 << $urandom_range(6, 31));
      if (k == 2 && m_wait >= 2)
        abort_xfer(a, w, d, int'($urandom_range(1, m_wait - 1)));
      else
        apb(a, w, d);
    end

    // asynchronous reset mid-wait
    apb(32'h00, 1'b1, 32'h0);
    apb(32'h10, 1'b1, 32'hCAFE_0001);
    apb(32'h00, 1'b1, 32'h5);
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h14; pwrite = 1'b1;
    pwdata = 32'h1111_2222;
    @(posedge hclk); #1;
    penable = 1'b1;
    repeat (2) @(posedge hclk);
    #3 hreset_n = 1'b0;
    #1;
    chk("rst_wait_pready", 32'(pready_x), 32'h0);
    chk("rst_wait_outs", prdata_x | 32'(pslverr_x), 32'h0);
    model_reset();
    sb.delete();
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge hclk);
    #1 hreset_n = 1'b1;
    apb(32'h00, 1'b0, 0);
    apb(32'h08, 1'b0, 0);
    apb(32'h10, 1'b0, 0);
    apb(32'h14, 1'b0, 0);
    apb(32'h04, 1'b0, 0);

    // asynchronous reset while pready is high
    sb.push_back(predict(32'h04, 1'b0, 0));
    @(posedge hclk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 32'h04; pwrite = 1'b0;
    @(posedge hclk); #1;
    penable = 1'b1;
    @(negedge hclk);
    #2 hreset_n = 1'b0;
    #1;
    chk("rst_ready_pready", 32'(pready_x), 32'h0);
    chk("rst_ready_prdata", prdata_x, 32'h0);
    model_reset();
    sb.delete();
    psel = 1'b0; penable = 1'b0;
    @(posedge hclk); #1 hreset_n = 1'b1;
    apb(32'h08, 1'b0, 0);

    @(negedge hclk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_expectations %0d pending, 0 required", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
